// File: rtl/spi_resp.sv
// spi_resp: SPI mode-0 responder with a one-byte TX buffer and RX holding register.
// Ports: clk/resetq; SPI pins sck, cs_n, mosi -> miso, miso_oe;
//        TX side wr, tx_data -> busy; RX side rd -> valid, rx_data, overrun.
module spi_resp #(
  parameter logic [7:0] FILL = 8'hFF,
  parameter int         SYNC = 2
) (
  input  logic       clk,
  input  logic       resetq,
  input  logic       sck,
  input  logic       cs_n,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  input  logic       wr,
  input  logic [7:0] tx_data,
  output logic       busy,
  input  logic       rd,
  output logic       valid,
  output logic [7:0] rx_data,
  output logic       overrun
);

  logic [SYNC-1:0] sck_q;
  logic [SYNC-1:0] cs_q;
  logic [SYNC-1:0] mosi_q;
  logic            sck_d;
  logic            cs_d;
  logic            sck_s;
  logic            cs_s;
  logic            mosi_s;

  logic [7:0]      tx_sh;
  logic [7:0]      tx_buf;
  logic [7:0]      rx_sh;
  logic [2:0]      cnt;
  logic            done;

  logic            sel;
  logic            desel;
  logic            rise;
  logic            fall;
  logic            load;
  logic [7:0]      next_tx;

  assign sck_s  = sck_q[SYNC-1];
  assign cs_s   = cs_q[SYNC-1];
  assign mosi_s = mosi_q[SYNC-1];

  // mosi goes through the same depth as sck so the sample lines up
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      sck_q  <= '0;
      cs_q   <= '1;
      mosi_q <= '0;
      sck_d  <= 1'b0;
      cs_d   <= 1'b1;
    end else begin
      sck_q  <= {sck_q[SYNC-2:0], sck};
      cs_q   <= {cs_q[SYNC-2:0], cs_n};
      mosi_q <= {mosi_q[SYNC-2:0], mosi};
      sck_d  <= sck_s;
      cs_d   <= cs_s;
    end
  end

  assign sel     = cs_d & ~cs_s;
  assign desel   = ~cs_d & cs_s;
  assign rise    = ~cs_s & sck_s & ~sck_d;
  assign fall    = ~cs_s & ~sck_s & sck_d;
  // shifter takes a new byte on select and on each byte boundary
  assign load    = sel | (fall & (cnt == 3'd0));
  assign next_tx = busy ? tx_buf : FILL;
  assign miso    = tx_sh[7];

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      tx_sh   <= '0;
      tx_buf  <= '0;
      busy    <= 1'b0;
      miso_oe <= 1'b0;
    end else begin
      if (load)
        tx_sh <= next_tx;
      else if (fall)
        tx_sh <= {tx_sh[6:0], 1'b0};
      // a write racing a load keeps the new byte buffered
      if (wr) begin
        tx_buf <= tx_data;
        busy   <= 1'b1;
      end else if (load) begin
        busy   <= 1'b0;
      end
      if (sel)
        miso_oe <= 1'b1;
      else if (desel)
        miso_oe <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      rx_sh   <= '0;
      cnt     <= '0;
      done    <= 1'b0;
      rx_data <= '0;
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (sel | desel)
        cnt <= '0;
      else if (rise)
        cnt <= cnt + 3'd1;
      if (rise)
        rx_sh <= {rx_sh[6:0], mosi_s};
      done <= rise & (cnt == 3'd7);
      // completion wins over rd; rd then only suppresses overrun
      if (done) begin
        rx_data <= rx_sh;
        valid   <= 1'b1;
        if (valid & ~rd)
          overrun <= 1'b1;
      end else if (rd) begin
        valid   <= 1'b0;
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_resp.sv
// tb_spi_resp: drives spi_resp as an SPI master and as the CPU,
// checking against a byte-level model of the buffers and flags.
module tb_spi_resp;

  localparam logic [7:0] FILL = 8'hFF;

  logic       clk;
  logic       resetq;
  logic       sck;
  logic       cs_n;
  logic       mosi;
  logic       miso;
  logic       miso_oe;
  logic       wr;
  logic [7:0] tx_data;
  logic       busy;
  logic       rd;
  logic       valid;
  logic [7:0] rx_data;
  logic       overrun;

  int n_tests;
  int n_fail;
  int cyc;
  int quiet_until;
  bit cmp_en;

  bit         m_busy;
  bit         m_valid;
  bit         m_ovr;
  bit         m_oe;
  logic [7:0] m_buf;
  logic [7:0] m_rx;
  logic [7:0] m_tx;

  spi_resp #(.FILL(FILL), .SYNC(2)) dut (
    .clk(clk), .resetq(resetq),
    .sck(sck), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe),
    .wr(wr), .tx_data(tx_data), .busy(busy),
    .rd(rd), .valid(valid), .rx_data(rx_data),
    .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: no end by %0t", $time);
    $fatal(1);
  end

  task automatic chk(input string nm,
                     input logic [7:0] act,
                     input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h want %02h at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic quiet();
    quiet_until = cyc + 4;
  endtask

  task automatic m_load();
    m_tx   = m_busy ? m_buf : FILL;
    m_busy = 1'b0;
  endtask

  task automatic m_done(input logic [7:0] b, input bit rd_same);
    if (m_valid && !rd_same)
      m_ovr = 1'b1;
    m_rx    = b;
    m_valid = 1'b1;
  endtask

  task automatic do_wr(input logic [7:0] d);
    wr      = 1'b1;
    tx_data = d;
    m_buf   = d;
    m_busy  = 1'b1;
    quiet();
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic do_rd();
    rd      = 1'b1;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
    quiet();
    @(negedge clk);
    rd = 1'b0;
  endtask

  task automatic sel_on();
    cs_n = 1'b0;
    m_load();
    m_oe = 1'b1;
    quiet();
    repeat (4) @(negedge clk);
  endtask

  task automatic sel_off();
    repeat (4) @(negedge clk);
    cs_n = 1'b1;
    m_oe = 1'b0;
    quiet();
    repeat (4) @(negedge clk);
  endtask

  task automatic xfer(input  logic [7:0] mo,
                      input  int         nbits,
                      input  bit         wr_mid,
                      input  logic [7:0] wd,
                      input  bit         rd_end,
                      output logic [7:0] mi);
    mi = '0;
    for (int i = 0; i < nbits; i++) begin
      mosi = mo[7-i];
      if (wr_mid && i == 3) begin
        wr      = 1'b1;
        tx_data = wd;
        m_buf   = wd;
        m_busy  = 1'b1;
        quiet();
        @(negedge clk);
        wr = 1'b0;
        repeat (3) @(negedge clk);
      end else begin
        repeat (4) @(negedge clk);
      end
      mi[7-i] = miso;
      chk("miso_bit", {7'd0, miso}, {7'd0, m_tx[7-i]});
      sck = 1'b1;
      quiet();
      if (i == 7) begin
        m_done(mo, rd_end);
        if (rd_end) begin
          repeat (3) @(negedge clk);
          rd = 1'b1;
          quiet();
          @(negedge clk);
          rd = 1'b0;
        end else begin
          repeat (4) @(negedge clk);
        end
        chk("valid_8th", {7'd0, valid}, {7'd0, m_valid});
        chk("rx_8th", rx_data, m_rx);
        chk("ovr_8th", {7'd0, overrun}, {7'd0, m_ovr});
      end else begin
        repeat (4) @(negedge clk);
      end
      sck = 1'b0;
      quiet();
      if (i == 7)
        m_load();
    end
  endtask

  task automatic run_all();
    logic [7:0] mi;
    logic [7:0] mi2;
    int         nb;
    int         nbits;
    bit         wm;
    bit         re;

    repeat (3) @(negedge clk);
    resetq = 1'b1;
    @(negedge clk);
    chk("rst_oe", {7'd0, miso_oe}, 8'h00);
    chk("rst_busy", {7'd0, busy}, 8'h00);
    chk("rst_valid", {7'd0, valid}, 8'h00);
    chk("rst_ovr", {7'd0, overrun}, 8'h00);
    chk("rst_rx", rx_data, 8'h00);
    chk("rst_miso", {7'd0, miso}, 8'h00);
    cmp_en = 1'b1;

    // A5 out, 3C in
    do_wr(8'hA5);
    sel_on();
    chk("t2_busy", {7'd0, busy}, 8'h00);
    chk("t2_oe", {7'd0, miso_oe}, 8'h01);
    xfer(8'h3C, 8, 1'b0, 8'h00, 1'b0, mi);
    chk("t2_mi", mi, 8'hA5);
    chk("t2_rx", rx_data, 8'h3C);
    chk("t2_valid", {7'd0, valid}, 8'h01);
    sel_off();

    // two bytes, no rd, FILL out
    do_rd();
    sel_on();
    xfer(8'h01, 8, 1'b0, 8'h00, 1'b0, mi);
    xfer(8'h02, 8, 1'b0, 8'h00, 1'b0, mi2);
    sel_off();
    chk("t3_mi1", mi, 8'hFF);
    chk("t3_mi2", mi2, 8'hFF);
    chk("t3_rx", rx_data, 8'h02);
    chk("t3_valid", {7'd0, valid}, 8'h01);
    chk("t3_ovr", {7'd0, overrun}, 8'h01);
    do_rd();
    @(negedge clk);
    chk("t3_valid_rd", {7'd0, valid}, 8'h00);
    chk("t3_ovr_rd", {7'd0, overrun}, 8'h00);

    // second byte written during the first
    do_wr(8'h11);
    sel_on();
    xfer(8'h55, 8, 1'b1, 8'h22, 1'b0, mi);
    xfer(8'hAA, 8, 1'b0, 8'h00, 1'b0, mi2);
    chk("t4_mi1", mi, 8'h11);
    chk("t4_mi2", mi2, 8'h22);
    chk("t4_busy", {7'd0, busy}, 8'h00);
    sel_off();

    // abort after 5 bits, then a clean byte
    do_rd();
    sel_on();
    xfer(8'hF0, 5, 1'b0, 8'h00, 1'b0, mi);
    sel_off();
    chk("t5_oe", {7'd0, miso_oe}, 8'h00);
    chk("t5_valid", {7'd0, valid}, 8'h00);
    sel_on();
    xfer(8'hC3, 8, 1'b0, 8'h00, 1'b0, mi);
    sel_off();
    chk("t5_rx", rx_data, 8'hC3);
    chk("t5_valid2", {7'd0, valid}, 8'h01);

    // rd coincides with completion
    do_rd();
    sel_on();
    xfer(8'h12, 8, 1'b0, 8'h00, 1'b0, mi);
    xfer(8'h77, 8, 1'b0, 8'h00, 1'b1, mi);
    sel_off();
    chk("t6_valid", {7'd0, valid}, 8'h01);
    chk("t6_rx", rx_data, 8'h77);
    chk("t6_ovr", {7'd0, overrun}, 8'h00);

    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(1, 0) == 1)
        do_wr(8'($urandom));
      if ($urandom_range(2, 0) == 0)
        do_rd();
      sel_on();
      nb = int'($urandom_range(3, 1));
      for (int b = 0; b < nb; b++) begin
        nbits = 8;
        if (b == nb - 1 && $urandom_range(4, 0) == 0)
          nbits = int'($urandom_range(7, 1));
        wm = ($urandom_range(3, 0) == 0);
        re = (nbits == 8) && ($urandom_range(3, 0) == 0);
        xfer(8'($urandom), nbits, wm, 8'($urandom), re, mi);
      end
      sel_off();
      repeat (int'($urandom_range(5, 0))) @(negedge clk);
    end

    // reset in the middle of a transfer
    sel_on();
    xfer(8'h96, 8, 1'b0, 8'h00, 1'b0, mi);
    xfer(8'h5A, 3, 1'b0, 8'h00, 1'b0, mi);
    do_wr(8'h3E);
    cmp_en = 1'b0;
    resetq = 1'b0;
    cs_n   = 1'b1;
    sck    = 1'b0;
    mosi   = 1'b0;
    #1;
    chk("mr_miso", {7'd0, miso}, 8'h00);
    chk("mr_oe", {7'd0, miso_oe}, 8'h00);
    chk("mr_busy", {7'd0, busy}, 8'h00);
    chk("mr_valid", {7'd0, valid}, 8'h00);
    chk("mr_rx", rx_data, 8'h00);
    chk("mr_ovr", {7'd0, overrun}, 8'h00);
    m_busy  = 1'b0;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
    m_oe    = 1'b0;
    m_rx    = 8'h00;
    @(negedge clk);
    resetq = 1'b1;
    quiet();
    cmp_en = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    cyc         = 0;
    quiet_until = 0;
    cmp_en      = 1'b0;
    m_busy      = 1'b0;
    m_valid     = 1'b0;
    m_ovr       = 1'b0;
    m_oe        = 1'b0;
    m_buf       = 8'h00;
    m_rx        = 8'h00;
    m_tx        = 8'h00;
    resetq      = 1'b0;
    sck         = 1'b0;
    cs_n        = 1'b1;
    mosi        = 1'b0;
    wr          = 1'b0;
    rd          = 1'b0;
    tx_data     = 8'h00;
    fork
      run_all();
      forever begin
        @(negedge clk);
        cyc++;
        if (cmp_en && cyc > quiet_until) begin
          chk("cmp_oe", {7'd0, miso_oe}, {7'd0, m_oe});
          chk("cmp_busy", {7'd0, busy}, {7'd0, m_busy});
          chk("cmp_valid", {7'd0, valid}, {7'd0, m_valid});
          chk("cmp_ovr", {7'd0, overrun}, {7'd0, m_ovr});
          chk("cmp_rx", rx_data, m_rx);
        end
      end
    join_any
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
